// File: rtl/pong_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : pong_pkg
//  Purpose : Shared constants for the Pong input front end. This includes the
//            key bit positions, the default debounce length, and a helper
//            that sizes the debounce counters.
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
package pong_pkg;

  // Bit positions of the paddle buttons in iKEY_n / oKEY_n / oPRESS
  localparam int KEY_UP1  = 0;
  localparam int KEY_DN1  = 1;
  localparam int KEY_UP2  = 2;
  localparam int KEY_DN2  = 3;
  localparam int NUM_KEYS = 4;

  // 20 ms at a 25 MHz pixel clock
  localparam int DEBOUNCE_DEFAULT = 500000;

  // Width of a counter that must be able to hold the value 'cycles'
  function automatic int cnt_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pong_debounce_ch.sv
`default_nettype none
// ============================================================================
//  Module  : pong_debounce_ch
//  Purpose : One conditioning channel. The raw input first passes through a
//            synchroniser chain. A new level is accepted only after the
//            synchronised value has differed from the accepted level for
//            DEBOUNCE_CYCLES consecutive cycles. Each accepted change
//            produces a registered one-cycle pulse.
//  Ports   : iVGA_CLK   in  1  clock, rising edge
//            iRST_n     in  1  asynchronous reset, active-low
//            raw        in  1  unsynchronised input
//            level      out 1  accepted (debounced) level
//            fall_pulse out 1  one cycle, coincident with level going 1->0
//            rise_pulse out 1  one cycle, coincident with level going 0->1
//  Rev     : 1.0  initial release
// ============================================================================
module pong_debounce_ch
  import pong_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int   SYNC_STAGES     = 2,
  parameter logic RST_VAL         = 1'b1
) (
  input  logic iVGA_CLK,
  input  logic iRST_n,
  input  logic raw,
  output logic level,
  output logic fall_pulse,
  output logic rise_pulse
);

  localparam int               CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt;
  logic                   sync;

  assign sync = sync_q[SYNC_STAGES-1];

  // Synchroniser: raw enters at bit 0 and leaves from the top bit
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
    end
  end

  // Debounce. Any sample that agrees with the accepted level restarts the
  // count, so a glitch shorter than DEBOUNCE_CYCLES never gets accepted.
  // The pulses are registered together with 'level' so that they line up
  // with the level change.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      level      <= RST_VAL;
      cnt        <= '0;
      fall_pulse <= 1'b0;
      rise_pulse <= 1'b0;
    end else begin
      fall_pulse <= 1'b0;
      rise_pulse <= 1'b0;
      if (sync == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level      <= sync;
        cnt        <= '0;
        fall_pulse <= ~sync;
        rise_pulse <= sync;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/pong_input_conditioner.sv
`default_nettype none
// ============================================================================
//  Module  : pong_input_conditioner
//  Purpose : Conditions the four active-low paddle buttons and the run switch
//            for vga_controller. It debounces each of them and masks the keys
//            while the game is held.
//  Ports   : iVGA_CLK in  1  pixel clock, rising edge
//            iRST_n   in  1  asynchronous reset, active-low
//            iKEY_n   in  4  raw buttons, active-low [0]=up1 [1]=dn1 [2]=up2 [3]=dn2
//            iSW      in  1  raw run switch, 1 = hold, 0 = play
//            oKEY_n   out 4  debounced, masked buttons, active-low
//            oSW      out 1  debounced switch level
//            oPRESS   out 4  one-cycle pulse per accepted press, masked
//            oSW_RISE out 1  one-cycle pulse, game stopped
//            oSW_FALL out 1  one-cycle pulse, game started
//  Rev     : 1.0  initial release
// ============================================================================
module pong_input_conditioner
  import pong_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int SYNC_STAGES     = 2
) (
  input  logic                iVGA_CLK,
  input  logic                iRST_n,
  input  logic [NUM_KEYS-1:0] iKEY_n,
  input  logic                iSW,
  output logic [NUM_KEYS-1:0] oKEY_n,
  output logic                oSW,
  output logic [NUM_KEYS-1:0] oPRESS,
  output logic                oSW_RISE,
  output logic                oSW_FALL
);

  logic [NUM_KEYS-1:0] key_level;
  logic [NUM_KEYS-1:0] key_fall;
  logic [NUM_KEYS-1:0] key_rise_unused;   // key releases raise no event
  logic                sw_level;
  logic                sw_rise;
  logic                sw_fall;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    pong_debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .SYNC_STAGES     (SYNC_STAGES),
      .RST_VAL         (1'b1)
    ) u_key_ch (
      .iVGA_CLK   (iVGA_CLK),
      .iRST_n     (iRST_n),
      .raw        (iKEY_n[k]),
      .level      (key_level[k]),
      .fall_pulse (key_fall[k]),
      .rise_pulse (key_rise_unused[k])
    );
  end

  // The switch resets to 1 so that the game starts out held.
  pong_debounce_ch #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .SYNC_STAGES     (SYNC_STAGES),
    .RST_VAL         (1'b1)
  ) u_sw_ch (
    .iVGA_CLK   (iVGA_CLK),
    .iRST_n     (iRST_n),
    .raw        (iSW),
    .level      (sw_level),
    .fall_pulse (sw_fall),
    .rise_pulse (sw_rise)
  );

  // The mask is driven by the switch's own level register. The keys
  // therefore unmask on the same edge that oSW falls. A key press accepted
  // on that edge still produces a pulse. A key that was already held shows
  // up as low with no pulse. Each term here is a channel flop, so no input
  // can reach an output without passing through a register.
  always_comb begin
    oSW      = sw_level;
    oSW_RISE = sw_rise;
    oSW_FALL = sw_fall;
    oKEY_n   = sw_level ? {NUM_KEYS{1'b1}} : key_level;
    oPRESS   = sw_level ? {NUM_KEYS{1'b0}} : key_fall;
  end

endmodule
`default_nettype wire

// File: tb/tb_pong_input_conditioner.sv
`default_nettype none
// ============================================================================
//  Module  : tb_pong_input_conditioner
//  Purpose : Self-checking bench for pong_input_conditioner with
//            DEBOUNCE_CYCLES=8 and SYNC_STAGES=2. A windowed reference model
//            is checked on every cycle, together with directed literal
//            scenarios and randomized input bursts.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_pong_input_conditioner;

  localparam int D = 8;
  localparam int S = 2;

  logic       iVGA_CLK = 1'b0;
  logic       iRST_n;
  logic [3:0] iKEY_n;
  logic       iSW;
  logic [3:0] oKEY_n;
  logic       oSW;
  logic [3:0] oPRESS;
  logic       oSW_RISE;
  logic       oSW_FALL;

  int checks = 0;
  int errors = 0;

  pong_input_conditioner #(
    .DEBOUNCE_CYCLES (D),
    .SYNC_STAGES     (S)
  ) dut (
    .iVGA_CLK (iVGA_CLK),
    .iRST_n   (iRST_n),
    .iKEY_n   (iKEY_n),
    .iSW      (iSW),
    .oKEY_n   (oKEY_n),
    .oSW      (oSW),
    .oPRESS   (oPRESS),
    .oSW_RISE (oSW_RISE),
    .oSW_FALL (oSW_FALL)
  );

  always #5 iVGA_CLK = ~iVGA_CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model. hist[c][0] holds the raw value sampled at the current
  // edge. The synchronised value seen at edge t is the raw value from edge
  // t-S. A channel flips at an edge exactly when each of the last D
  // synchronised samples (hist indices S .. S+D-1) disagrees with the
  // accepted level. Channels 0..3 are the keys and channel 4 is the switch.
  // --------------------------------------------------------------------------
  logic       hist [5][S+D];
  logic [4:0] m_stable;
  logic [4:0] m_flip;

  always @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      for (int c = 0; c < 5; c++)
        for (int k = 0; k < S+D; k++) hist[c][k] = 1'b1;
      m_stable = 5'h1F;
      m_flip   = 5'h00;
    end else begin
      logic [4:0] raw;
      raw = {iSW, iKEY_n};
      for (int c = 0; c < 5; c++) begin
        logic all_diff;
        for (int k = S+D-1; k > 0; k--) hist[c][k] = hist[c][k-1];
        hist[c][0] = raw[c];
        all_diff = 1'b1;
        for (int k = S; k < S+D; k++)
          if (hist[c][k] == m_stable[c]) all_diff = 1'b0;
        m_flip[c] = all_diff;
        if (all_diff) m_stable[c] = ~m_stable[c];
      end
    end
  end

  // Compare process: outputs only move on rising edges, so sample at falling.
  always @(negedge iVGA_CLK) begin
    logic       e_sw;
    logic [3:0] e_key, e_press;
    e_sw    = m_stable[4];
    e_key   = e_sw ? 4'hF : m_stable[3:0];
    e_press = e_sw ? 4'h0 : (m_flip[3:0] & ~m_stable[3:0]);
    check("model_okey",  32'(oKEY_n),   32'(e_key));
    check("model_osw",   32'(oSW),      32'(e_sw));
    check("model_press", 32'(oPRESS),   32'(e_press));
    check("model_rise",  32'(oSW_RISE), 32'(m_flip[4] &  m_stable[4]));
    check("model_fall",  32'(oSW_FALL), 32'(m_flip[4] & ~m_stable[4]));
  end

  // Advance n rising edges and then stop at the following falling edge
  task automatic edges(input int n);
    repeat (n) @(posedge iVGA_CLK);
    @(negedge iVGA_CLK);
  endtask

  task automatic async_reset_pulse();
    @(posedge iVGA_CLK);
    #3 iRST_n = 1'b0;
    #1;
    check("arst_okey",  32'(oKEY_n),   32'hF);
    check("arst_osw",   32'(oSW),      32'h1);
    check("arst_press", 32'(oPRESS),   32'h0);
    check("arst_rise",  32'(oSW_RISE), 32'h0);
    check("arst_fall",  32'(oSW_FALL), 32'h0);
    @(negedge iVGA_CLK);
    iRST_n = 1'b1;
  endtask

  initial begin
    iRST_n = 1'b0;
    iKEY_n = 4'hF;
    iSW    = 1'b1;
    repeat (3) @(negedge iVGA_CLK);
    check("rst_okey", 32'(oKEY_n), 32'hF);
    check("rst_osw",  32'(oSW),    32'h1);
    iRST_n = 1'b1;

    // 1. Reset in the middle of a count throws away the partial count
    iSW = 1'b0; iKEY_n = 4'h0;
    edges(5);
    async_reset_pulse();
    edges(9);
    check("t1_osw_held", 32'(oSW), 32'h1);
    edges(1);
    check("t1_fall",  32'(oSW_FALL), 32'h1);
    check("t1_okey",  32'(oKEY_n),   32'h0);
    check("t1_press", 32'(oPRESS),   32'hF);
    iKEY_n = 4'hF;
    edges(20);

    // 2. Single press: output changes 10 edges later, with one pulse
    iKEY_n = 4'hE;
    edges(9);
    check("t2_okey_early", 32'(oKEY_n[0]), 32'h1);
    edges(1);
    check("t2_okey",   32'(oKEY_n[0]), 32'h0);
    check("t2_press",  32'(oPRESS),    32'h1);
    edges(1);
    check("t2_press_1cyc", 32'(oPRESS), 32'h0);
    iKEY_n = 4'hF;
    for (int i = 0; i < 15; i++) begin
      edges(1);
      check("t2_release_nopulse", 32'(oPRESS), 32'h0);
    end
    check("t2_released", 32'(oKEY_n), 32'hF);

    // 3. Bounce: 7 low, 1 high, 7 low. It must never be accepted.
    for (int i = 0; i < 30; i++) begin
      iKEY_n = (i < 7 || (i >= 8 && i < 15)) ? 4'hB : 4'hF;
      edges(1);
      check("t3_okey2",  32'(oKEY_n[2]), 32'h1);
      check("t3_press2", 32'(oPRESS[2]), 32'h0);
    end

    // 4. Mask while held. The key held through the unmask shows low with
    //    no pulse.
    iSW = 1'b1;
    edges(12);
    check("t4_osw", 32'(oSW), 32'h1);
    iKEY_n = 4'h7;
    for (int i = 0; i < 20; i++) begin
      edges(1);
      check("t4_masked_okey",  32'(oKEY_n), 32'hF);
      check("t4_masked_press", 32'(oPRESS), 32'h0);
    end
    iSW = 1'b0;
    edges(9);
    check("t4_osw_early", 32'(oSW), 32'h1);
    edges(1);
    check("t4_fall",  32'(oSW_FALL), 32'h1);
    check("t4_okey",  32'(oKEY_n),   32'h7);
    check("t4_press", 32'(oPRESS),   32'h0);
    iKEY_n = 4'hF;
    edges(12);

    // 5. Two keys pressed together
    iKEY_n = 4'hC;
    edges(9);
    check("t5_okey_early", 32'(oKEY_n), 32'hF);
    edges(1);
    check("t5_okey",  32'(oKEY_n), 32'hC);
    check("t5_press", 32'(oPRESS), 32'h3);

    // 6. Game stopped: the keys are forced high on the same edge
    iSW = 1'b1;
    edges(9);
    check("t6_okey_early", 32'(oKEY_n), 32'hC);
    edges(1);
    check("t6_rise", 32'(oSW_RISE), 32'h1);
    check("t6_okey", 32'(oKEY_n),   32'hF);
    edges(1);
    check("t6_rise_1cyc", 32'(oSW_RISE), 32'h0);
    iKEY_n = 4'hF;
    edges(12);

    // Randomized bursts, with one asynchronous reset part way through
    for (int seg = 0; seg < 160; seg++) begin
      int len;
      if (seg == 80) async_reset_pulse();
      if ($urandom_range(0, 5) == 0) iSW = ~iSW;
      iKEY_n = 4'($urandom);
      len = (($urandom_range(0, 2) == 0) ? $urandom_range(8, 16) : $urandom_range(1, 9));
      edges(len);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
